// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one read at a time on a
// valid/ready memory port and holds each returned word until the consumer takes it.
module ysyx_24100005_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_arvalid,
    output logic [31:0] imem_araddr,
    input  logic        imem_arready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rerr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        BOOT,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_kill;
    logic        r_arvalid;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fetch_err;

    logic        w_pc_aligned;
    logic [31:0] w_seq_pc;
    logic [31:0] w_resume_pc;

    function automatic logic f_aligned(input logic [1:0] lo);
        return lo == 2'b00;
    endfunction

    assign w_pc_aligned = f_aligned(r_pc[1:0]);
    assign w_seq_pc     = r_pc + PC_STEP;
    // A redirect arriving with the stale response beats the parked pend_pc.
    assign w_resume_pc  = redirect_valid ? redirect_pc : r_pend_pc;

    // NOTE: every state register uses <= so all updates see pre-edge values;
    // arvalid is decided on entry to REQ so a misaligned PC never reaches the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_pend_pc    <= '0;
            r_kill       <= 1'b0;
            r_arvalid    <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_fetch_err  <= 1'b0;
        end else begin
            case (r_state)
                BOOT: begin
                    if (redirect_valid) begin
                        r_pc      <= redirect_pc;
                        r_arvalid <= f_aligned(redirect_pc[1:0]);
                    end else begin
                        r_arvalid <= w_pc_aligned;
                    end
                    r_state <= REQ;
                end
                REQ: begin
                    if (!w_pc_aligned) begin
                        if (redirect_valid) begin
                            r_pc      <= redirect_pc;
                            r_arvalid <= f_aligned(redirect_pc[1:0]);
                        end else begin
                            r_inst       <= '0;
                            r_inst_pc    <= r_pc;
                            r_fetch_err  <= 1'b1;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end else begin
                        // An offered request cannot be withdrawn; park the redirect.
                        if (redirect_valid) begin
                            r_kill    <= 1'b1;
                            r_pend_pc <= redirect_pc;
                        end
                        if (imem_arready) begin
                            r_arvalid <= 1'b0;
                            r_state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (r_kill || redirect_valid) begin
                            r_kill    <= 1'b0;
                            r_pc      <= w_resume_pc;
                            r_arvalid <= f_aligned(w_resume_pc[1:0]);
                            r_state   <= REQ;
                        end else begin
                            r_inst       <= imem_rdata;
                            r_inst_pc    <= r_pc;
                            r_fetch_err  <= imem_rerr;
                            r_inst_valid <= 1'b1;
                            r_state      <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_kill    <= 1'b1;
                        r_pend_pc <= redirect_pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= redirect_pc;
                        r_arvalid    <= f_aligned(redirect_pc[1:0]);
                        r_state      <= REQ;
                    end else if (inst_ready) begin
                        r_inst_valid <= 1'b0;
                        r_pc         <= w_seq_pc;
                        r_arvalid    <= f_aligned(w_seq_pc[1:0]);
                        r_state      <= REQ;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign imem_arvalid = r_arvalid;
    assign imem_araddr  = r_pc;
    assign inst_valid   = r_inst_valid;
    assign inst         = r_inst;
    assign inst_pc      = r_inst_pc;
    assign fetch_err    = r_fetch_err;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
// Directed bench for the fetch unit: the memory side is driven by hand, step by step.
module tb_ysyx_24100005_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_arvalid;
    logic [31:0] imem_araddr;
    logic        imem_arready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_rerr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_err;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int errors = 0;
    int checks = 0;

    ysyx_24100005_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_arvalid   (imem_arvalid),
        .imem_araddr    (imem_araddr),
        .imem_arready   (imem_arready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .imem_rerr      (imem_rerr),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_err      (fetch_err),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // From REQ at addr: accept at once, answer next cycle, then check the held word.
    task automatic zw_fetch(input logic [31:0] addr, input logic [31:0] data, input logic err);
        check("req_arvalid", {31'b0, imem_arvalid}, 32'd1);
        check("req_araddr", imem_araddr, addr);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        check("wait_arvalid", {31'b0, imem_arvalid}, 32'd0);
        check("wait_ivalid", {31'b0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        imem_rerr   = err;
        tick();
        imem_rvalid = 1'b0;
        imem_rerr   = 1'b0;
        check("hold_ivalid", {31'b0, inst_valid}, 32'd1);
        check("hold_inst", inst, data);
        check("hold_pc", inst_pc, addr);
        check("hold_err", {31'b0, fetch_err}, {31'b0, err});
        check("hold_arvalid", {31'b0, imem_arvalid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        imem_arready   = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        imem_rerr      = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        tick();
        tick();
        check("rst_arvalid", {31'b0, imem_arvalid}, 32'd0);
        check("rst_ivalid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);
        rst = 1'b0;
        tick();

        // arready low for four cycles: request must sit unchanged, accepted on the fifth
        for (int i = 0; i < 4; i++) begin
            check("stall_arvalid", {31'b0, imem_arvalid}, 32'd1);
            check("stall_araddr", imem_araddr, 32'h8000_0000);
            tick();
        end
        zw_fetch(32'h8000_0000, 32'h0000_0013, 1'b0);

        // zero-wait streaming with an always-ready consumer
        inst_ready = 1'b1;
        tick();
        zw_fetch(32'h8000_0004, 32'h0010_0093, 1'b0);
        tick();
        zw_fetch(32'h8000_0008, 32'h0020_0113, 1'b0);

        // consumer stall in HOLD
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("cstall_ivalid", {31'b0, inst_valid}, 32'd1);
            check("cstall_inst", inst, 32'h0020_0113);
            check("cstall_pc", inst_pc, 32'h8000_0008);
            check("cstall_arvalid", {31'b0, imem_arvalid}, 32'd0);
        end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("after_hs_arvalid", {31'b0, imem_arvalid}, 32'd1);
        check("after_hs_araddr", imem_araddr, 32'h8000_000C);

        // redirect while waiting: returned word is dropped
        imem_arready = 1'b1;
        tick();
        imem_arready   = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        check("kill_ivalid0", {31'b0, inst_valid}, 32'd0);
        check("kill_arvalid0", {31'b0, imem_arvalid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("kill_ivalid1", {31'b0, inst_valid}, 32'd0);
        zw_fetch(32'h8000_0100, 32'h0030_0193, 1'b0);

        // redirect and inst_ready together in HOLD
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        tick();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("rdr_hold_ivalid", {31'b0, inst_valid}, 32'd0);
        check("rdr_hold_arvalid", {31'b0, imem_arvalid}, 32'd1);
        check("rdr_hold_araddr", imem_araddr, 32'h8000_0200);

        // redirects while the request is unaccepted; the last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        tick();
        check("req_kill_arvalid", {31'b0, imem_arvalid}, 32'd1);
        check("req_kill_araddr", imem_araddr, 32'h8000_0200);
        redirect_pc  = 32'h8000_0400;
        imem_arready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_arready   = 1'b0;
        check("req_kill_wait_arvalid", {31'b0, imem_arvalid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0200;
        tick();
        imem_rvalid = 1'b0;
        check("last_wins_ivalid", {31'b0, inst_valid}, 32'd0);
        check("last_wins_araddr", imem_araddr, 32'h8000_0400);
        check("last_wins_arvalid", {31'b0, imem_arvalid}, 32'd1);

        // redirect and response in the same WAIT cycle, to a misaligned PC
        imem_arready = 1'b1;
        tick();
        imem_arready   = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hBAD0_0400;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        check("mis_req_arvalid", {31'b0, imem_arvalid}, 32'd0);
        check("mis_req_ivalid", {31'b0, inst_valid}, 32'd0);
        tick();
        check("mis_ivalid", {31'b0, inst_valid}, 32'd1);
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_inst", inst, 32'h0);
        check("mis_pc", inst_pc, 32'h8000_0102);
        check("mis_arvalid", {31'b0, imem_arvalid}, 32'd0);

        // bus error reported on the fetched instruction
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        tick();
        redirect_valid = 1'b0;
        zw_fetch(32'h8000_0500, 32'h0010_0073, 1'b1);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        zw_fetch(32'hFFFF_FFFC, 32'h0000_006F, 1'b0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("wrap_araddr", imem_araddr, 32'h0000_0000);
        check("wrap_arvalid", {31'b0, imem_arvalid}, 32'd1);

        // reset mid-transaction, then a stale response while booting
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        rst = 1'b1;
        tick();
        check("mrst_arvalid", {31'b0, imem_arvalid}, 32'd0);
        check("mrst_ivalid", {31'b0, inst_valid}, 32'd0);
        check("mrst_inst", inst, 32'h0);
        rst         = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0000;
        tick();
        imem_rvalid = 1'b0;
        check("mrst_araddr", imem_araddr, 32'h8000_0000);
        check("mrst_arvalid1", {31'b0, imem_arvalid}, 32'd1);
        tick();
        check("mrst_stale_ivalid", {31'b0, inst_valid}, 32'd0);
        check("mrst_stale_araddr", imem_araddr, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
